// File: rtl/mem_arbiter_vid.sv
// Arbitrates a single-ported SRAM between the RISC5 CPU and the display refresh engine.
// Video reads fixed-length bursts. The CPU is frozen with stallX for the whole burst.
// A guaranteed run of CPU-owned cycles separates consecutive bursts.
// Ports:
//   clk, rst                         clock and asynchronous active-high reset
//   cpu_adr/rd/wr/ben/wdata/rdata    CPU memory port; cpu_rdata is mem_rdata passed through
//   stallX                           high while video owns the memory
//   vid_req/adr/ack/valid/data       burst request, base address, grant pulse, word delivery
//   mem_adr/rd/wr/be/wdata/rdata     SRAM port; read data is valid in the same cycle as the address
module mem_arbiter_vid #(
    parameter int ADR_W   = 24,
    parameter int BURST   = 8,
    parameter int VWAIT   = 0,
    parameter int MIN_CPU = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic             cpu_ben,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             stallX,
    input  logic             vid_req,
    input  logic [ADR_W-1:0] vid_adr,
    output logic             vid_ack,
    output logic             vid_valid,
    output logic [31:0]      vid_data,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    // Counter widths. Each width is at least 1 bit so that degenerate parameter values still elaborate.
    localparam int GW = (MIN_CPU < 1) ? 1 : $clog2(MIN_CPU + 1);
    localparam int WW = (VWAIT < 1) ? 1 : $clog2(VWAIT + 1);
    localparam int BW = (BURST < 2) ? 1 : $clog2(BURST);

    typedef enum logic {S_CPU, S_VID} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    gcnt;
    logic [WW-1:0]    wcnt;
    logic [BW-1:0]    bcnt;
    logic [ADR_W-1:0] vadr;

    logic grant;
    logic word_done;
    logic last_word;

    assign grant     = (state == S_CPU) && vid_req && (gcnt == GW'(MIN_CPU));
    assign word_done = (state == S_VID) && (wcnt == WW'(VWAIT));
    assign last_word = word_done && (bcnt == BW'(BURST - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory-port steering. The steering depends only on the registered state,
    // so stallX never forms a combinational path back from the CPU inputs.
    always_comb begin
        state_nxt = state;
        stallX    = 1'b0;
        mem_adr   = cpu_adr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_be    = cpu_ben ? 4'(4'b0001 << cpu_adr[1:0]) : 4'hF;
        case (state)
            S_CPU: begin
                if (grant) begin
                    state_nxt = S_VID;
                end
            end
            S_VID: begin
                stallX  = 1'b1;
                mem_adr = vadr;
                mem_rd  = 1'b1;
                mem_wr  = 1'b0;
                mem_be  = 4'hF;
                if (last_word) begin
                    state_nxt = S_CPU;
                end
            end
            default: state_nxt = S_CPU;
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign mem_wdata = cpu_wdata;

    // Burst bookkeeping and video outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt      <= GW'(MIN_CPU);
            vadr      <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            vid_ack   <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            vid_ack   <= grant;
            vid_valid <= word_done;
            if (state == S_CPU) begin
                // Count CPU-owned cycles since the last burst, saturating at the required gap
                if (gcnt != GW'(MIN_CPU)) begin
                    gcnt <= gcnt + 1'b1;
                end
                if (grant) begin
                    vadr <= vid_adr;
                    wcnt <= '0;
                    bcnt <= '0;
                end
            end else begin
                if (word_done) begin
                    vid_data <= mem_rdata;
                    vadr     <= vadr + ADR_W'(4);
                    wcnt     <= '0;
                    bcnt     <= bcnt + 1'b1;
                    if (last_word) begin
                        gcnt <= '0;
                    end
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

endmodule
